// File: rtl/matmul_ctrl_pkg.sv
// matmul_ctrl_pkg: shared FSM state encoding and address sizing helper for matmul controllers
package matmul_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_FIN   = 2'd3;
  function automatic int prod_w(input int a, input int b);
    return a + b;
  endfunction
endpackage

// File: rtl/tile_loop_counter.sv
// tile_loop_counter: nested k/c/r loop counter with enable, wrap flags and last flag
module tile_loop_counter import matmul_ctrl_pkg::*; #(
  parameter int DIM_W = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIM_W-1:0] m2,
  input  logic [DIM_W-1:0] mc,
  input  logic [DIM_W-1:0] mr,
  output logic [DIM_W-1:0] k,
  output logic [DIM_W-1:0] c,
  output logic [DIM_W-1:0] r,
  output logic             k_wrap,
  output logic             last
);
  logic c_wrap;
  // wrap points of each loop level
  always_comb begin
    k_wrap = k == m2 - DIM_W'(1);
    c_wrap = k_wrap && c == mc - DIM_W'(1);
    last   = c_wrap && r == mr - DIM_W'(1);
  end
  // k innermost, then c, then r; everything returns to 0 after the last step
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      k <= '0;
      c <= '0;
      r <= '0;
    end else if (en) begin
      k <= k_wrap ? '0 : k + DIM_W'(1);
      c <= c_wrap ? '0 : c + DIM_W'(k_wrap);
      r <= last ? '0 : r + DIM_W'(c_wrap);
    end
  end
endmodule

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: tiled matmul loop-nest sequencer with A/B reads, PE init pulses and C write-back
module matmul_tile_sequencer import matmul_ctrl_pkg::*; #(
  parameter int N1       = 4,
  parameter int N2       = 4,
  parameter int DIM_W    = 16,
  parameter int ADDR_W_A = 12,
  parameter int ADDR_W_B = 12,
  parameter int ADDR_W_C = 12
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  input  logic [DIM_W-1:0]    M2,
  input  logic [DIM_W-1:0]    M1dN1,
  input  logic [DIM_W-1:0]    M3dN2,
  input  logic                transpose_b,
  output logic                busy,
  output logic                done,
  output logic                rd_valid,
  output logic [ADDR_W_A-1:0] rd_addr_A,
  output logic [ADDR_W_B-1:0] rd_addr_B,
  output logic [N1*N2-1:0]    init,
  output logic                wr_valid,
  output logic [ADDR_W_C-1:0] wr_addr_C
);
  localparam int PW = prod_w(DIM_W, DIM_W);
  localparam int D  = N1 + N2;
  state_t state;
  logic [DIM_W-1:0] m2_q, m1_q, m3_q, k, c, r;
  logic tb_q, k_wrap, last, run, adv, go;
  logic [D:0] sh;
  logic [ADDR_W_C-1:0] dl [D+1];
  logic [ADDR_W_C-1:0] tile_addr;
  assign run = state == S_RUN;
  assign adv = run & ~stall;
  assign go  = state == S_IDLE & start & ~stall;
  tile_loop_counter #(.DIM_W(DIM_W)) u_loop (
    .clk(clk), .rst(rst), .clr(go), .en(adv),
    .m2(m2_q), .mc(m3_q), .mr(m1_q),
    .k(k), .c(c), .r(r), .k_wrap(k_wrap), .last(last)
  );
  // full-width address products truncated to each port width; stall blanks every strobe
  always_comb begin
    rd_valid  = adv;
    rd_addr_A = ADDR_W_A'(PW'(r) * PW'(m2_q) + PW'(k));
    rd_addr_B = tb_q ? ADDR_W_B'(PW'(c) * PW'(m2_q) + PW'(k)) : ADDR_W_B'(PW'(k) * PW'(m3_q) + PW'(c));
    tile_addr = ADDR_W_C'(PW'(r) * PW'(m3_q) + PW'(c));
    wr_valid  = sh[D] & ~stall;
    wr_addr_C = dl[D];
    busy      = state != S_IDLE;
    done      = state == S_FIN & ~stall;
  end
  for (genvar i = 0; i < N1; i++) begin : g_row
    for (genvar j = 0; j < N2; j++) begin : g_col
      assign init[i*N2+j] = sh[i+j+1] & ~stall;
    end
  end
  // job capture and IDLE/RUN/DRAIN/FIN sequencing; a zero dimension skips straight to FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      m2_q  <= '0;
      m1_q  <= '0;
      m3_q  <= '0;
      tb_q  <= 1'b0;
    end else if (!stall) begin
      if (go) begin
        m2_q  <= M2;
        m1_q  <= M1dN1;
        m3_q  <= M3dN2;
        tb_q  <= transpose_b;
        state <= (M2 == '0 || M1dN1 == '0 || M3dN2 == '0) ? S_FIN : S_RUN;
      end else if (run && last)
        state <= S_DRAIN;
      else if (state == S_DRAIN && sh[D-1:0] == '0)
        state <= S_FIN;
      else if (state == S_FIN)
        state <= S_IDLE;
    end
  end
  // tile-complete token and its C tile address travel together down the array diagonal
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      for (int n = 0; n <= D; n++) dl[n] <= '0;
    end else if (!stall) begin
      sh    <= {sh[D-1:0], run & k_wrap};
      dl[0] <= tile_addr;
      for (int n = 1; n <= D; n++) dl[n] <= dl[n-1];
    end
  end
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb_matmul_tile_sequencer: scoreboard bench with directed jobs for the tile sequencer
module tb_matmul_tile_sequencer;
  localparam int N1 = 2, N2 = 2, DW = 16, AW = 12;
  logic clk = 0, rst = 1, start = 0, stall = 0, transpose_b = 0;
  logic [DW-1:0] M2 = 0, M1dN1 = 0, M3dN2 = 0;
  logic busy, done, rd_valid, wr_valid;
  logic [AW-1:0] rd_addr_A, rd_addr_B, wr_addr_C;
  logic [N1*N2-1:0] init;
  int errors = 0, checks = 0, cyc = 0, t0 = 0, rel;
  int qa[$], qb[$], qc[$];
  int rd_cnt, wr_cnt, wr_first, wr_last, init0_at, init3_at, done_cnt, done_at, busy_first, busy_last;
  int a2[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
  int b2[12] = '{0, 2, 4, 1, 3, 5, 0, 2, 4, 1, 3, 5};
  int b3[12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};

  matmul_tile_sequencer #(.N1(N1), .N2(N2), .DIM_W(DW), .ADDR_W_A(AW), .ADDR_W_B(AW), .ADDR_W_C(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .M2(M2), .M1dN1(M1dN1), .M3dN2(M3dN2),
    .transpose_b(transpose_b), .busy(busy), .done(done), .rd_valid(rd_valid), .rd_addr_A(rd_addr_A),
    .rd_addr_B(rd_addr_B), .init(init), .wr_valid(wr_valid), .wr_addr_C(wr_addr_C)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input int a, input int b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  task automatic clr_marks();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    wr_first = -1; wr_last = -1; init0_at = -1; init3_at = -1;
    done_at = -1; busy_first = -1; busy_last = -1;
  endtask

  // monitor: pops the scoreboard on every read/write strobe and logs event timing
  always @(negedge clk) begin
    if (!rst) begin
      rel = cyc - t0;
      if (rd_valid) begin
        rd_cnt++;
        if (qa.size() == 0) chk("rd_unexpected", rd_addr_A, -1);
        else begin
          chk("rd_addr_A", rd_addr_A, qa.pop_front());
          chk("rd_addr_B", rd_addr_B, qb.pop_front());
        end
      end
      if (wr_valid) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = rel;
        wr_last = rel;
        if (qc.size() == 0) chk("wr_unexpected", wr_addr_C, -1);
        else chk("wr_addr_C", wr_addr_C, qc.pop_front());
      end
      if (init[0] && init0_at < 0) init0_at = rel;
      if (init[3] && init3_at < 0) init3_at = rel;
      if (done) begin done_cnt++; done_at = rel; end
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (stall) chk("stall_quiet", {rd_valid, wr_valid, |init}, 0);
    end
  end

  task automatic start_job(input int m2, input int m1, input int m3, input int tbm);
    @(negedge clk);
    M2 = m2; M1dN1 = m1; M3dN2 = m3; transpose_b = tbm[0]; start = 1;
    t0 = cyc;
    clr_marks();
    @(negedge clk);
    start = 0;
    #1;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) begin @(posedge clk); #1; end
  endtask

  task automatic finish_job(input int exp_rd, input int exp_wr, input int exp_done);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 200) begin @(negedge clk); #1; n++; end
    repeat (3) @(negedge clk);
    #1;
    chk("done_cnt", done_cnt, 1);
    chk("done_at", done_at, exp_done);
    chk("rd_cnt", rd_cnt, exp_rd);
    chk("wr_cnt", wr_cnt, exp_wr);
    chk("rd_left", qa.size(), 0);
    chk("wr_left", qc.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_marks();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_init", init, 0);
    chk("rst_addr_A", rd_addr_A, 0);

    // single tile, k-major B
    for (int i = 0; i < 4; i++) push_rd(i, i);
    qc.push_back(0);
    start_job(4, 1, 1, 0);
    finish_job(4, 1, 10);
    chk("t1_init0", init0_at, 6);
    chk("t1_init3", init3_at, 8);
    chk("t1_wr", wr_first, 9);
    chk("t1_busy_first", busy_first, 1);
    chk("t1_busy_last", busy_last, 10);

    // 2x2 tiles, k-major B
    for (int i = 0; i < 12; i++) push_rd(a2[i], b2[i]);
    for (int i = 0; i < 4; i++) qc.push_back(i);
    start_job(3, 2, 2, 0);
    finish_job(12, 4, 18);
    chk("t2_wr_first", wr_first, 8);
    chk("t2_wr_last", wr_last, 17);

    // same job, tile-major B
    for (int i = 0; i < 12; i++) push_rd(a2[i], b3[i]);
    for (int i = 0; i < 4; i++) qc.push_back(i);
    start_job(3, 2, 2, 1);
    finish_job(12, 4, 18);

    // single tile with a 3-cycle stall after the second read
    for (int i = 0; i < 4; i++) push_rd(i, i);
    qc.push_back(0);
    start_job(4, 1, 1, 0);
    wait_rel(3);
    stall = 1;
    repeat (3) @(posedge clk);
    #1 stall = 0;
    finish_job(4, 1, 13);
    chk("t4_init0", init0_at, 9);
    chk("t4_init3", init3_at, 11);
    chk("t4_wr", wr_first, 12);
    chk("t4_busy_last", busy_last, 13);

    // M2=1: back-to-back write-backs, start while busy ignored
    for (int i = 0; i < 4; i++) push_rd(0, i);
    for (int i = 0; i < 4; i++) qc.push_back(i);
    start_job(1, 1, 4, 0);
    wait_rel(3);
    start = 1; M2 = 2;
    @(posedge clk);
    #1 start = 0;
    finish_job(4, 4, 10);
    chk("t5_wr_first", wr_first, 6);
    chk("t5_wr_last", wr_last, 9);

    // zero dimension: straight to FIN
    start_job(2, 0, 2, 0);
    finish_job(0, 0, 1);
    chk("t6_busy_last", busy_last, 1);

    // reset in the middle of RUN
    for (int i = 0; i < 4; i++) push_rd(i, i);
    qc.push_back(0);
    start_job(4, 1, 1, 0);
    wait_rel(3);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    qa.delete(); qb.delete(); qc.delete();
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_rd_valid", rd_valid, 0);
    chk("mr_addr_A", rd_addr_A, 0);
    chk("mr_addr_B", rd_addr_B, 0);
    chk("mr_init", init, 0);
    chk("mr_wr_valid", wr_valid, 0);
    chk("mr_addr_C", wr_addr_C, 0);

    // clean restart after reset
    for (int i = 0; i < 4; i++) push_rd(i, i);
    qc.push_back(0);
    start_job(4, 1, 1, 0);
    finish_job(4, 1, 10);
    chk("rr_wr", wr_first, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
